// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and data access.
// Data has priority; a starvation counter forces fetch after STARVE_MAX data grants.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_done,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_done,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                stallF,
  output logic                stallM
);

  localparam int CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
  logic             eligible_if, eligible_d;
  logic             grant_if, grant_d;
  logic             finish;

  assign stallF = if_req & ~if_done;
  assign stallM = d_req & ~d_done;

  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    grant_if        = 1'b0;
    grant_d         = 1'b0;
    finish          = 1'b0;
    // A requester still seeing its own done pulse is not asking for a new access yet.
    eligible_if     = if_req & ~if_done;
    eligible_d      = d_req & ~d_done;
    case (state_reg)
      IDLE: begin
        if (eligible_if && (!eligible_d || starve_cnt_reg == CNT_MAX)) begin
          grant_if        = 1'b1;
          state_next      = FETCH;
          starve_cnt_next = '0;
        end else if (eligible_d) begin
          grant_d    = 1'b1;
          state_next = DATA;
          if (if_req && starve_cnt_reg != CNT_MAX) begin
            starve_cnt_next = starve_cnt_reg + CNT_W'(1);
          end
        end
      end
      FETCH, DATA: begin
        if (mem_ready) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_be         <= '0;
      if_rdata       <= '0;
      d_rdata        <= '0;
      if_done        <= 1'b0;
      d_done         <= 1'b0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      if_done        <= 1'b0;
      d_done         <= 1'b0;
      if (grant_if) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_be    <= '1;
      end else if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_be    <= d_be;
      end else if (finish) begin
        mem_req <= 1'b0;
        if (state_reg == FETCH) begin
          if_rdata <= mem_rdata;
          if_done  <= 1'b1;
        end else begin
          // Stores leave the last load result untouched.
          if (!mem_we) begin
            d_rdata <= mem_rdata;
          end
          d_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (STARVE_MAX=2): latency, priority, starvation,
// stores with wait states, input sampling at grant and reset mid-access.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stallF;
  logic        stallM;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stallF(stallF), .stallM(stallM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the grant cycle; returns in the done cycle.
  task automatic access(input string tag, input logic [31:0] addr, input logic we,
                        input int waits, input logic [31:0] rdata);
    step();
    check_val({tag, "_req"}, mem_req, 1'b1);
    check_val({tag, "_addr"}, mem_addr, addr);
    check_val({tag, "_we"}, mem_we, we);
    for (int i = 0; i < waits; i++) begin
      step();
      check_val({tag, "_hold"}, mem_addr, addr);
    end
    mem_ready = 1'b1;
    mem_rdata = rdata;
    step();
    mem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_be = '0; mem_rdata = '0; mem_ready = 1'b0;
    step(); step();
    check_val("rst_mem_req", mem_req, 1'b0);
    check_val("rst_mem_we", mem_we, 1'b0);
    check_val("rst_mem_addr", mem_addr, 32'h0);
    check_val("rst_mem_wdata", mem_wdata, 32'h0);
    check_val("rst_mem_be", mem_be, 4'h0);
    check_val("rst_if_done", if_done, 1'b0);
    check_val("rst_d_done", d_done, 1'b0);
    check_val("rst_if_rdata", if_rdata, 32'h0);
    check_val("rst_d_rdata", d_rdata, 32'h0);
    rst = 1'b1;
    step();

    // Fetch only, zero wait states
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    check_val("t1_c0_stallF", stallF, 1'b1);
    check_val("t1_c0_mem_req", mem_req, 1'b0);
    step();
    check_val("t1_c1_mem_req", mem_req, 1'b1);
    check_val("t1_c1_mem_addr", mem_addr, 32'h100);
    check_val("t1_c1_mem_be", mem_be, 4'hF);
    check_val("t1_c1_mem_we", mem_we, 1'b0);
    check_val("t1_c1_stallF", stallF, 1'b1);
    check_val("t1_c1_if_done", if_done, 1'b0);
    mem_ready = 1'b1; mem_rdata = 32'h00500093;
    step();
    mem_ready = 1'b0;
    check_val("t1_c2_if_done", if_done, 1'b1);
    check_val("t1_c2_if_rdata", if_rdata, 32'h00500093);
    check_val("t1_c2_stallF", stallF, 1'b0);
    check_val("t1_c2_mem_req", mem_req, 1'b0);
    check_val("t1_c2_d_done", d_done, 1'b0);
    if_req = 1'b0;
    step();
    check_val("t1_c3_if_done", if_done, 1'b0);
    check_val("t1_c3_mem_req", mem_req, 1'b0);

    // Simultaneous requests: data first, fetch granted in the d_done cycle
    if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_be = 4'hF;
    access("t2_data", 32'h200, 1'b0, 0, 32'h11223344);
    check_val("t2_d_done", d_done, 1'b1);
    check_val("t2_d_rdata", d_rdata, 32'h11223344);
    check_val("t2_if_done_lo", if_done, 1'b0);
    check_val("t2_stallM", stallM, 1'b0);
    check_val("t2_stallF", stallF, 1'b1);
    d_req = 1'b0;
    access("t2_fetch", 32'h104, 1'b0, 0, 32'hAAAA0001);
    check_val("t2_if_done", if_done, 1'b1);
    check_val("t2_if_rdata", if_rdata, 32'hAAAA0001);
    check_val("t2_d_done_lo", d_done, 1'b0);
    check_val("t2_d_rdata_keep", d_rdata, 32'h11223344);
    if_req = 1'b0;
    step();
    check_val("t2_if_done_end", if_done, 1'b0);

    // Starvation bound: two data grants with fetch pending, then fetch is forced
    if_req = 1'b1; if_addr = 32'h10C;
    d_req = 1'b1; d_addr = 32'h210;
    access("t3_d1", 32'h210, 1'b0, 0, 32'h1);
    check_val("t3_d1_done", d_done, 1'b1);
    if_req = 1'b0; d_req = 1'b0;
    step();
    check_val("t3_gap1_req", mem_req, 1'b0);
    if_req = 1'b1; d_req = 1'b1; d_addr = 32'h214;
    access("t3_d2", 32'h214, 1'b0, 0, 32'h2);
    check_val("t3_d2_done", d_done, 1'b1);
    if_req = 1'b0; d_req = 1'b0;
    step();
    check_val("t3_gap2_req", mem_req, 1'b0);
    if_req = 1'b1; d_req = 1'b1; d_addr = 32'h218;
    access("t3_forced_fetch", 32'h10C, 1'b0, 0, 32'h3);
    check_val("t3_if_done", if_done, 1'b1);
    check_val("t3_if_rdata", if_rdata, 32'h3);
    if_req = 1'b0;
    access("t3_d3", 32'h218, 1'b0, 0, 32'h4);
    check_val("t3_d3_done", d_done, 1'b1);
    check_val("t3_d3_rdata", d_rdata, 32'h4);
    d_req = 1'b0;
    step();
    // Counter was cleared by the fetch grant, so data wins again
    if_req = 1'b1; if_addr = 32'h110; d_req = 1'b1; d_addr = 32'h21C;
    access("t3_cnt_cleared", 32'h21C, 1'b0, 0, 32'h5);
    check_val("t3_d4_done", d_done, 1'b1);
    if_req = 1'b0; d_req = 1'b0;
    step();

    // Store with 3 wait states; inputs changed after grant are ignored
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'hDEADBEEF; d_be = 4'h3;
    step();
    d_we = 1'b0; d_addr = 32'h999; d_wdata = 32'h0; d_be = 4'hF;
    for (int i = 0; i < 4; i++) begin
      check_val("t4_mem_req", mem_req, 1'b1);
      check_val("t4_mem_we", mem_we, 1'b1);
      check_val("t4_mem_addr", mem_addr, 32'h300);
      check_val("t4_mem_wdata", mem_wdata, 32'hDEADBEEF);
      check_val("t4_mem_be", mem_be, 4'h3);
      check_val("t4_d_done_lo", d_done, 1'b0);
      if (i == 3) begin
        mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
      end
      step();
    end
    mem_ready = 1'b0;
    check_val("t4_d_done", d_done, 1'b1);
    check_val("t4_d_rdata_keep", d_rdata, 32'h5);
    check_val("t4_mem_req_lo", mem_req, 1'b0);
    d_req = 1'b0;
    step();
    check_val("t4_d_done_once", d_done, 1'b0);

    // Fetch address changed during wait states
    if_req = 1'b1; if_addr = 32'h100;
    step();
    check_val("t6_mem_addr", mem_addr, 32'h100);
    if_addr = 32'h104;
    for (int i = 0; i < 2; i++) begin
      step();
      check_val("t6_mem_addr_hold", mem_addr, 32'h100);
      check_val("t6_if_done_lo", if_done, 1'b0);
    end
    mem_ready = 1'b1; mem_rdata = 32'h00000013;
    step();
    mem_ready = 1'b0;
    check_val("t6_if_done", if_done, 1'b1);
    check_val("t6_if_rdata", if_rdata, 32'h00000013);
    if_req = 1'b0;
    step();

    // Reset in the middle of a data access
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; d_be = 4'hF;
    step();
    check_val("t5_mem_req", mem_req, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_val("t5_async_req", mem_req, 1'b0);
    check_val("t5_async_done", d_done, 1'b0);
    d_req = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    check_val("t5_post_d_done", d_done, 1'b0);
    check_val("t5_post_mem_req", mem_req, 1'b0);
    check_val("t5_post_d_rdata", d_rdata, 32'h0);
    if_req = 1'b1; if_addr = 32'h500;
    access("t5_fetch", 32'h500, 1'b0, 1, 32'hABCD1234);
    check_val("t5_if_done", if_done, 1'b1);
    check_val("t5_if_rdata", if_rdata, 32'hABCD1234);
    check_val("t5_d_done_lo", d_done, 1'b0);
    if_req = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
